// File: rtl/fib_lpm_table.sv
// Hashed, direct-mapped FIB with longest-prefix-match lookup.
// A lookup probes one prefix length per cycle, walking down from the request length to 0.
module fib_lpm_table #(
  parameter int unsigned PREFIX_W = 64,
  parameter int unsigned HASH_W   = 6,
  parameter int unsigned FACE_W   = 4,
  localparam int unsigned LEN_W   = $clog2(PREFIX_W + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_valid,
  output logic                ins_ready,
  input  logic                ins_del,
  input  logic [PREFIX_W-1:0] ins_prefix,
  input  logic [LEN_W-1:0]    ins_len,
  input  logic [FACE_W-1:0]   ins_face,
  input  logic                lu_valid,
  output logic                lu_ready,
  input  logic [PREFIX_W-1:0] lu_prefix,
  input  logic [LEN_W-1:0]    lu_len,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_hit,
  output logic [LEN_W-1:0]    res_len,
  output logic [FACE_W-1:0]   res_face,
  output logic [PREFIX_W-1:0] res_prefix,
  output logic [HASH_W:0]     fib_count
);

  localparam int unsigned Depth   = 2 ** HASH_W;
  localparam int unsigned NChunks = (PREFIX_W + HASH_W - 1) / HASH_W;
  localparam logic [HASH_W:0]  CountOne = 1;
  localparam logic [LEN_W-1:0] LenOne   = 1;
  localparam logic [LEN_W-1:0] LenMax   = LEN_W'(PREFIX_W);

  typedef enum logic [1:0] {StIdle, StProbe, StResp} state_e;

  function automatic logic [PREFIX_W-1:0] mask_f(input logic [PREFIX_W-1:0] p,
                                                 input logic [LEN_W-1:0]    l);
    return p & ~({PREFIX_W{1'b1}} >> l);
  endfunction

  // Shifting the masked prefix right zero-extends the last, short chunk.
  function automatic logic [HASH_W-1:0] hash_f(input logic [PREFIX_W-1:0] p,
                                               input logic [LEN_W-1:0]    l);
    logic [PREFIX_W-1:0] m;
    logic [HASH_W-1:0]   h;
    m = mask_f(p, l);
    h = '0;
    for (int i = 0; i < NChunks; i++) begin
      h = h ^ HASH_W'(m >> (i * HASH_W));
    end
    return h ^ HASH_W'(l);
  endfunction

  function automatic logic [LEN_W-1:0] clamp_f(input logic [LEN_W-1:0] l);
    return (l > LenMax) ? LenMax : l;
  endfunction

  state_e               state_q, state_d;
  logic [PREFIX_W-1:0]  pfx_q, pfx_d;
  logic [LEN_W-1:0]     plen_q, plen_d;
  logic                 res_hit_q, res_hit_d;
  logic [LEN_W-1:0]     res_len_q, res_len_d;
  logic [FACE_W-1:0]    res_face_q, res_face_d;
  logic [PREFIX_W-1:0]  res_prefix_q, res_prefix_d;
  logic [HASH_W:0]      count_q, count_d;
  logic [Depth-1:0]     valid_q, valid_d;

  logic [LEN_W-1:0]     len_q  [Depth];
  logic [PREFIX_W-1:0]  tag_q  [Depth];
  logic [FACE_W-1:0]    face_q [Depth];

  logic                 wr_en;
  logic [LEN_W-1:0]     ins_len_c;
  logic [HASH_W-1:0]    ins_idx;
  logic [PREFIX_W-1:0]  ins_tag;
  logic                 ins_match;
  logic [HASH_W-1:0]    probe_idx;
  logic [PREFIX_W-1:0]  probe_tag;
  logic                 probe_hit;

  always_comb begin
    ins_len_c = clamp_f(ins_len);
    ins_tag   = mask_f(ins_prefix, ins_len_c);
    ins_idx   = hash_f(ins_prefix, ins_len_c);
    ins_match = valid_q[ins_idx] && (len_q[ins_idx] == ins_len_c) && (tag_q[ins_idx] == ins_tag);
    probe_tag = mask_f(pfx_q, plen_q);
    probe_idx = hash_f(pfx_q, plen_q);
    probe_hit = valid_q[probe_idx] && (len_q[probe_idx] == plen_q) &&
                (tag_q[probe_idx] == probe_tag);
  end

  always_comb begin
    state_d      = state_q;
    pfx_d        = pfx_q;
    plen_d       = plen_q;
    res_hit_d    = res_hit_q;
    res_len_d    = res_len_q;
    res_face_d   = res_face_q;
    res_prefix_d = res_prefix_q;
    count_d      = count_q;
    valid_d      = valid_q;
    wr_en        = 1'b0;
    ins_ready    = 1'b0;
    lu_ready     = 1'b0;
    unique case (state_q)
      StIdle: begin
        ins_ready = 1'b1;
        lu_ready  = !ins_valid;
        if (ins_valid) begin
          if (ins_del) begin
            if (ins_match) begin
              valid_d[ins_idx] = 1'b0;
              count_d          = count_q - CountOne;
            end
          end else begin
            wr_en            = 1'b1;
            valid_d[ins_idx] = 1'b1;
            if (!valid_q[ins_idx]) count_d = count_q + CountOne;
          end
        end else if (lu_valid) begin
          pfx_d   = lu_prefix;
          plen_d  = clamp_f(lu_len);
          state_d = StProbe;
        end
      end
      StProbe: begin
        if (probe_hit) begin
          res_hit_d    = 1'b1;
          res_len_d    = plen_q;
          res_face_d   = face_q[probe_idx];
          res_prefix_d = probe_tag;
          state_d      = StResp;
        end else if (plen_q == '0) begin
          res_hit_d    = 1'b0;
          res_len_d    = '0;
          res_face_d   = '0;
          res_prefix_d = '0;
          state_d      = StResp;
        end else begin
          plen_d = plen_q - LenOne;
        end
      end
      StResp: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pfx_q        <= '0;
      plen_q       <= '0;
      res_hit_q    <= 1'b0;
      res_len_q    <= '0;
      res_face_q   <= '0;
      res_prefix_q <= '0;
      count_q      <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      pfx_q        <= pfx_d;
      plen_q       <= plen_d;
      res_hit_q    <= res_hit_d;
      res_len_q    <= res_len_d;
      res_face_q   <= res_face_d;
      res_prefix_q <= res_prefix_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
    end
  end

  // Entry payload needs no reset: the valid vector qualifies every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      len_q[ins_idx]  <= ins_len_c;
      tag_q[ins_idx]  <= ins_tag;
      face_q[ins_idx] <= ins_face;
    end
  end

  assign res_valid  = (state_q == StResp);
  assign res_hit    = res_hit_q;
  assign res_len    = res_len_q;
  assign res_face   = res_face_q;
  assign res_prefix = res_prefix_q;
  assign fib_count  = count_q;

endmodule

// File: tb/tb_fib_lpm_table.sv
// Scoreboard bench for fib_lpm_table: driver pushes model results, a monitor pops and compares.
// The reference model searches a plain array table bit by bit, longest length first.
module tb_fib_lpm_table;

  logic        clk;
  logic        rst;
  logic        ins_valid, ins_ready, ins_del;
  logic [63:0] ins_prefix;
  logic [6:0]  ins_len;
  logic [3:0]  ins_face;
  logic        lu_valid, lu_ready;
  logic [63:0] lu_prefix;
  logic [6:0]  lu_len;
  logic        res_valid, res_ready, res_hit;
  logic [6:0]  res_len;
  logic [3:0]  res_face;
  logic [63:0] res_prefix;
  logic [6:0]  fib_count;

  fib_lpm_table #(.PREFIX_W(64), .HASH_W(6), .FACE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_del    (ins_del),
    .ins_prefix (ins_prefix),
    .ins_len    (ins_len),
    .ins_face   (ins_face),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_prefix  (lu_prefix),
    .lu_len     (lu_len),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_hit    (res_hit),
    .res_len    (res_len),
    .res_face   (res_face),
    .res_prefix (res_prefix),
    .fib_count  (fib_count)
  );

  typedef struct {
    logic        hit;
    logic [6:0]  len;
    logic [3:0]  face;
    logic [63:0] pfx;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic have_cur = 1'b0;
  logic hold_rr  = 1'b0;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;

  // Reference table
  logic        mv [64];
  int          ml [64];
  logic [63:0] mt [64];
  logic [3:0]  mf [64];
  int          m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    res_ready = hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  function automatic logic [63:0] m_mask(input logic [63:0] p, input int l);
    logic [63:0] r = '0;
    for (int b = 0; b < 64; b++) if (b >= 64 - l) r[b] = p[b];
    return r;
  endfunction

  function automatic int m_hash(input logic [63:0] p, input int l);
    logic [63:0] m = m_mask(p, l);
    int h = 0;
    for (int b = 0; b < 64; b++) if (m[b]) h = h ^ (1 << (b % 6));
    return h ^ (l % 64);
  endfunction

  function automatic int m_clamp(input int l);
    return (l > 64) ? 64 : l;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic void m_write(input logic del, input logic [63:0] p, input int lr,
                                  input logic [3:0] f);
    int l = m_clamp(lr);
    int i = m_hash(p, l);
    if (del) begin
      if (mv[i] && ml[i] == l && mt[i] == m_mask(p, l)) begin
        mv[i] = 1'b0;
        m_cnt--;
      end
    end else begin
      if (!mv[i]) m_cnt++;
      mv[i] = 1'b1;
      ml[i] = l;
      mt[i] = m_mask(p, l);
      mf[i] = f;
    end
  endfunction

  function automatic exp_t m_lookup(input logic [63:0] p, input int lr);
    exp_t e;
    int l = m_clamp(lr);
    e.hit = 1'b0;
    e.len = '0;
    e.face = '0;
    e.pfx = '0;
    e.acc = 0;
    e.lat = l + 1;
    for (int k = l; k >= 0; k--) begin
      int i = m_hash(p, k);
      if (mv[i] && ml[i] == k && mt[i] == m_mask(p, k)) begin
        e.hit = 1'b1;
        e.len = 7'(k);
        e.face = mf[i];
        e.pfx = m_mask(p, k);
        e.lat = l - k + 1;
        return e;
      end
    end
    return e;
  endfunction

  // Monitor: pops on the first result cycle, then checks the fields stay put until accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && res_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            fail("res_unexpected", "result presented with empty scoreboard");
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk("res_latency", 64'(cyc - cur.acc), 64'(cur.lat));
            chk("res_hit", 64'(res_hit), 64'(cur.hit));
            chk("res_len", 64'(res_len), 64'(cur.len));
            chk("res_face", 64'(res_face), 64'(cur.face));
            chk("res_prefix", res_prefix, cur.pfx);
          end
        end else begin
          chk("hold_fields", {res_prefix[51:0], res_face, res_len, res_hit},
              {cur.pfx[51:0], cur.face, cur.len, cur.hit});
        end
        if (res_ready) have_cur = 1'b0;
      end
    end
  end

  // Driver tasks start and end at posedge + 1.
  task automatic do_ins(input logic del, input logic [63:0] p, input int l, input logic [3:0] f);
    int n = 0;
    ins_valid = 1'b1;
    ins_del = del;
    ins_prefix = p;
    ins_len = 7'(l);
    ins_face = f;
    @(negedge clk);
    while (!ins_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ins_ready) fail("ins_timeout", "ins_ready never rose");
    else m_write(del, p, l, f);
    @(posedge clk);
    #1;
    ins_valid = 1'b0;
    chk("fib_count", 64'(fib_count), 64'(m_cnt));
  endtask

  task automatic do_lu(input logic [63:0] p, input int l);
    int n = 0;
    exp_t e;
    lu_valid = 1'b1;
    lu_prefix = p;
    lu_len = 7'(l);
    @(negedge clk);
    while (!lu_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!lu_ready) begin
      fail("lu_timeout", "lu_ready never rose");
    end else begin
      e = m_lookup(p, l);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    lu_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || have_cur) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) fail("idle_timeout", "outstanding lookup never completed");
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    @(negedge clk);
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_fields", {res_prefix[53:0], res_face, res_len, res_hit}, 64'(0));
    chk("rst_fib_count", 64'(fib_count), 64'(0));
    chk("rst_ins_ready", 64'(ins_ready), 64'(1));
    chk("rst_lu_ready", 64'(lu_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  logic [63:0] pool [6];
  logic [63:0] ins_p [$];
  int          ins_l [$];

  initial begin
    rst = 1'b1;
    ins_valid = 1'b0;
    ins_del = 1'b0;
    ins_prefix = '0;
    ins_len = '0;
    ins_face = '0;
    lu_valid = 1'b0;
    lu_prefix = '0;
    lu_len = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_outputs();

    // Empty-table miss, then nested routes
    do_lu(64'hAB00_0000_0000_0000, 16);
    wait_idle();
    chk("empty_count", 64'(fib_count), 64'(0));
    do_ins(1'b0, 64'hAB00_0000_0000_0000, 8, 4'd3);
    do_ins(1'b0, 64'hABCD_0000_0000_0000, 16, 4'd5);
    do_lu(64'hABCD_EF00_0000_0000, 24);
    wait_idle();
    chk("two_routes_count", 64'(fib_count), 64'(2));
    do_ins(1'b1, 64'hABCD_0000_0000_0000, 16, 4'd0);
    do_lu(64'hABCD_EF00_0000_0000, 24);
    wait_idle();
    chk("after_del_count", 64'(fib_count), 64'(1));
    do_ins(1'b1, 64'h1234_0000_0000_0000, 20, 4'd0);
    chk("del_missing_count", 64'(fib_count), 64'(1));
    do_ins(1'b0, 64'h0, 0, 4'd9);
    do_lu(64'h5000_0000_0000_0000, 4);
    wait_idle();

    // Simultaneous insert and lookup, then a held result
    hold_rr = 1'b1;
    ins_valid = 1'b1;
    ins_del = 1'b0;
    ins_prefix = 64'hC0DE_0000_0000_0000;
    ins_len = 7'd12;
    ins_face = 4'd7;
    lu_valid = 1'b1;
    lu_prefix = 64'hC0DE_F000_0000_0000;
    lu_len = 7'd90;
    @(negedge clk);
    chk("both_ins_ready", 64'(ins_ready), 64'(1));
    chk("both_lu_ready", 64'(lu_ready), 64'(0));
    if (ins_ready) m_write(1'b0, 64'hC0DE_0000_0000_0000, 12, 4'd7);
    @(posedge clk);
    #1;
    ins_valid = 1'b0;
    @(negedge clk);
    chk("next_lu_ready", 64'(lu_ready), 64'(1));
    if (lu_ready) begin
      cur = m_lookup(64'hC0DE_F000_0000_0000, 90);
      cur.acc = cyc + 1;
      exp_q.push_back(cur);
    end
    @(posedge clk);
    #1;
    lu_valid = 1'b0;
    for (int n = 0; n < 200 && !have_cur; n++) @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("hold_res_valid", 64'(res_valid), 64'(1));
    hold_rr = 1'b0;
    wait_idle();

    // Reset in the middle of a long probe walk
    do_lu(64'hAB12_3456_789A_BCDE, 64);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    have_cur = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    chk_reset_outputs();
    do_lu(64'hAB00_0000_0000_0000, 8);
    wait_idle();

    // Randomised traffic over a small prefix pool so routes nest and collide
    for (int i = 0; i < 6; i++) pool[i] = {$urandom, $urandom};
    for (int op = 0; op < 300; op++) begin
      int r = $urandom_range(0, 9);
      logic [63:0] p = pool[$urandom_range(0, 5)];
      if (r < 4) begin
        int l = $urandom_range(0, 70);
        do_ins(1'b0, p, l, 4'($urandom));
        ins_p.push_back(p);
        ins_l.push_back(l);
      end else if (r < 6) begin
        if (ins_p.size() != 0 && $urandom_range(0, 1) == 1) begin
          int k = $urandom_range(0, ins_p.size() - 1);
          do_ins(1'b1, ins_p[k], ins_l[k], 4'd0);
        end else begin
          do_ins(1'b1, p, $urandom_range(0, 70), 4'd0);
        end
      end else begin
        logic [63:0] noise = {$urandom, $urandom};
        do_lu(p ^ (noise >> $urandom_range(0, 64)), $urandom_range(0, 70));
      end
    end
    wait_idle();
    chk("final_count", 64'(fib_count), 64'(m_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
